// File: rtl/dce_pkg.sv
// Shared types and constants for the UART DCE loopback model.
package dce_pkg;

  localparam int DATA_W           = 8;
  localparam int BAUD_DIV_DEFAULT = 87;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/dce_loopback_if.sv
// UART line and flow-control bundle between a DTE (master) and the DCE (slave).
interface dce_loopback_if;
  import dce_pkg::*;

  // rts=1: DTE can take a character, so the DCE may start one (checked only between characters).
  // cts=1: DCE has room and the DTE may start a character. txd/rxd idle high.
  logic        rts;
  logic        cts;
  logic        txd;
  logic        rxd;
  uart_state_t rx_state;
  uart_state_t tx_state;

  modport master (
    output rts,
    output txd,
    input  cts,
    input  rxd,
    input  rx_state,
    input  tx_state
  );

  modport slave (
    input  rts,
    input  txd,
    output cts,
    output rxd,
    output rx_state,
    output tx_state
  );

endinterface

// File: rtl/dce_byte_fifo.sv
// Synchronous FIFO with registered storage; simultaneous push and pop both take effect.
module dce_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dce_loopback.sv
// UART DCE loopback: receives 8N1 on txd, buffers in a FIFO, retransmits on rxd with RTS/CTS.
module dce_loopback
  import dce_pkg::*;
#(
  parameter int BAUD_DIV     = BAUD_DIV_DEFAULT,
  parameter int FIFO_DEPTH   = 16,
  parameter int CTS_HEADROOM = 2
) (
  input logic           clock,
  input logic           reset,
  dce_loopback_if.slave uart
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] DBR;
  logic [31:0] full_m1;
  logic [31:0] half_m1;

  assign DBR     = 32'(BAUD_DIV);
  assign full_m1 = DBR - 32'd1;
  assign half_m1 = (DBR >> 1) - 32'd1;

  logic sync_meta;
  logic s_txd;
  logic s_txd_d;
  logic rx_fall;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= 1'b1;
      s_txd     <= 1'b1;
      s_txd_d   <= 1'b1;
    end else begin
      sync_meta <= uart.txd;
      s_txd     <= sync_meta;
      s_txd_d   <= s_txd;
    end
  end

  assign rx_fall = s_txd_d & ~s_txd;

  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W-1:0] fifo_dout;
  logic [DATA_W-1:0] rx_shift;
  logic [CNT_W-1:0]  fifo_count;

  dce_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (rx_shift),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  logic cts_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cts_q <= 1'b0;
    end else begin
      cts_q <= (FIFO_DEPTH - int'(fifo_count)) > CTS_HEADROOM;
    end
  end

  assign uart.cts = cts_q;

  // ---------------- receive FSM ----------------
  uart_state_t rx_state;
  uart_state_t rx_next;
  logic [31:0] rx_cnt;
  logic [2:0]  rx_bits;
  logic        rx_tick;

  assign rx_tick = (rx_cnt == 32'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state <= IDLE;
    end else begin
      rx_state <= rx_next;
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      IDLE:  if (rx_fall) rx_next = START;
      START: if (rx_tick) rx_next = s_txd ? IDLE : DATA;
      DATA:  if (rx_tick && rx_bits == 3'd7) rx_next = STOP;
      STOP:  if (rx_tick) rx_next = IDLE;
      default: rx_next = IDLE;
    endcase
  end

  // Push only on a good stop bit with room; a full FIFO silently drops the byte.
  always_comb begin
    push = (rx_state == STOP) && rx_tick && s_txd && !fifo_full;
  end

  // Counters run down to zero; the half-period load centres sampling in each bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        IDLE: begin
          if (rx_fall) rx_cnt <= half_m1;
        end
        START: begin
          if (rx_tick) begin
            rx_cnt  <= s_txd ? 32'd0 : full_m1;
            rx_bits <= '0;
          end else begin
            rx_cnt <= rx_cnt - 32'd1;
          end
        end
        DATA: begin
          if (rx_tick) begin
            rx_cnt   <= full_m1;
            rx_shift <= {s_txd, rx_shift[DATA_W-1:1]};
            rx_bits  <= rx_bits + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - 32'd1;
          end
        end
        STOP: begin
          rx_cnt <= rx_tick ? 32'd0 : rx_cnt - 32'd1;
        end
        default: rx_cnt <= '0;
      endcase
    end
  end

  // ---------------- transmit FSM ----------------
  uart_state_t       tx_state;
  uart_state_t       tx_next;
  logic [31:0]       tx_cnt;
  logic [2:0]        tx_bits;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_tick;
  logic              rxd_q;
  logic              rxd_d;

  assign tx_tick = (tx_cnt == 32'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= IDLE;
    end else begin
      tx_state <= tx_next;
    end
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      IDLE:  if (!fifo_empty && uart.rts) tx_next = START;
      START: if (tx_tick) tx_next = DATA;
      DATA:  if (tx_tick && tx_bits == 3'd7) tx_next = STOP;
      STOP:  if (tx_tick) tx_next = IDLE;
      default: tx_next = IDLE;
    endcase
  end

  // rxd_d is the line level for the next cycle, so each bit change lands on the register.
  always_comb begin
    pop   = 1'b0;
    rxd_d = rxd_q;
    case (tx_state)
      IDLE: begin
        if (!fifo_empty && uart.rts) begin
          pop   = 1'b1;
          rxd_d = 1'b0;
        end
      end
      START: if (tx_tick) rxd_d = tx_shift[0];
      DATA:  if (tx_tick) rxd_d = (tx_bits == 3'd7) ? 1'b1 : tx_shift[1];
      STOP:  if (tx_tick) rxd_d = 1'b1;
      default: rxd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rxd_q    <= 1'b1;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_shift <= '0;
    end else begin
      rxd_q <= rxd_d;
      case (tx_state)
        IDLE: begin
          if (pop) begin
            tx_shift <= fifo_dout;
            tx_cnt   <= full_m1;
          end
        end
        START: begin
          if (tx_tick) begin
            tx_cnt  <= full_m1;
            tx_bits <= '0;
          end else begin
            tx_cnt <= tx_cnt - 32'd1;
          end
        end
        DATA: begin
          if (tx_tick) begin
            tx_cnt   <= full_m1;
            tx_shift <= tx_shift >> 1;
            tx_bits  <= tx_bits + 3'd1;
          end else begin
            tx_cnt <= tx_cnt - 32'd1;
          end
        end
        STOP: begin
          tx_cnt <= tx_tick ? 32'd0 : tx_cnt - 32'd1;
        end
        default: tx_cnt <= '0;
      endcase
    end
  end

  assign uart.rxd      = rxd_q;
  assign uart.rx_state = rx_state;
  assign uart.tx_state = tx_state;

endmodule

// File: tb/tb_dce_loopback.sv
// Directed bench for dce_loopback: echo timing, flow control, glitch/framing, overflow, mid-character events.
module tb_dce_loopback;
  import dce_pkg::*;

  localparam int BD   = 87;
  localparam int HALF = BD / 2;
  // txd falls -> 2 sync -> edge detect -> half bit -> 9 bit periods to stop sample -> 1 pop cycle
  localparam int ECHO_LAT = 2 + 1 + HALF + 9 * BD + 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  dce_loopback_if uart ();

  dce_loopback #(
    .BAUD_DIV     (BD),
    .FIFO_DEPTH   (16),
    .CTS_HEADROOM (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .uart  (uart)
  );

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int unsigned rxd_low_cnt = 0;
  always @(negedge clock) if (uart.rxd === 1'b0) rxd_low_cnt <= rxd_low_cnt + 1;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_rd = 0;
  int         n_cmp  = 0;
  int         n_err  = 0;

  // Line decoder for rxd: centre-samples each character into got_q.
  initial begin : rxd_decoder
    logic [7:0] d;
    d = '0;
    forever begin
      @(negedge clock);
      if (uart.rxd === 1'b0 && reset === 1'b0) begin
        repeat (HALF) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clock);
          d[i] = uart.rxd;
        end
        repeat (BD) @(negedge clock);
        got_q.push_back(d);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    uart.txd = 1'b0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      uart.txd = b[i];
      tick(BD);
    end
    uart.txd = stop_v;
    tick(BD);
    uart.txd = 1'b1;
  endtask

  task automatic wait_echo(input int n, input string tag);
    int         guard;
    logic [7:0] e;
    guard = 0;
    while ((got_q.size() - got_rd) < n && guard < 1000 * n + 2000) begin
      @(negedge clock);
      guard++;
    end
    chk({tag, "_n"}, got_q.size() - got_rd, n);
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      if (got_rd < got_q.size()) begin
        chk($sformatf("%s_%0d", tag, i), got_q[got_rd], e);
        got_rd++;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int unsigned k;
    int unsigned m;
    int unsigned f;
    int unsigned base;
    int          guard;
    logic [7:0]  pat;
    logic        v;

    reset    = 1'b1;
    uart.rts = 1'b0;
    uart.txd = 1'b1;
    tick(1);
    tick(4);
    chk("rst_rxd", uart.rxd, 1'b1);
    chk("rst_cts", uart.cts, 1'b0);
    chk("rst_rx_state", uart.rx_state, IDLE);
    chk("rst_tx_state", uart.tx_state, IDLE);
    tick(6);
    reset = 1'b0;
    chk("post_rst_cts_low", uart.cts, 1'b0);
    tick(1);
    chk("post_rst_cts_high", uart.cts, 1'b1);
    chk("dbr", dut.DBR, 32'd87);
    chk("post_rst_count", dut.fifo_count, 0);

    // Single echo of 0x55 with exact bit timing.
    uart.rts = 1'b1;
    pat      = 8'h55;
    tick(1);
    k = cyc;
    guard = 0;
    fork
      send_byte(pat, 1'b1);
      begin
        while (uart.rxd !== 1'b0 && guard < 2000) begin
          tick(1);
          guard++;
        end
        chk("echo_latency", cyc - k, ECHO_LAT);
        f = cyc;
        for (int b = 0; b < 10; b++) begin
          v = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : pat[b-1];
          chk($sformatf("bit%0d_first", b), uart.rxd, v);
          tick(BD - 1);
          chk($sformatf("bit%0d_last", b), uart.rxd, v);
          tick(1);
        end
        chk("bit_span", cyc - f, 10 * BD);
      end
    join
    exp_q.push_back(8'h55);
    wait_echo(1, "echo_55");

    // Buffer 14 bytes with rts low, then release them.
    uart.rts = 1'b0;
    base = rxd_low_cnt;
    for (int i = 0; i < 14; i++) begin
      send_byte(8'(i), 1'b1);
      exp_q.push_back(8'(i));
      if (i == 12) chk("cts_after_13", uart.cts, 1'b1);
    end
    chk("cts_after_14", uart.cts, 1'b0);
    tick(200);
    chk("hold_rxd_idle", rxd_low_cnt - base, 0);
    chk("hold_no_echo", got_q.size() - got_rd, 0);
    uart.rts = 1'b1;
    m = cyc;
    tick(1);
    chk("flow_first_start", uart.rxd, 1'b0);
    chk("cts_before_pop_seen", uart.cts, 1'b0);
    tick(1);
    chk("cts_after_pop", uart.cts, 1'b1);
    tick(869);
    chk("b2b_gap_idle", uart.rxd, 1'b1);
    tick(1);
    chk("b2b_second_start", uart.rxd, 1'b0);
    chk("b2b_second_at", cyc - m, 872);
    wait_echo(14, "flow_order");

    // Glitch: 20 low cycles must not start a character.
    tick(100);
    base = rxd_low_cnt;
    uart.txd = 1'b0;
    tick(10);
    chk("glitch_detect", uart.rx_state, START);
    tick(10);
    uart.txd = 1'b1;
    tick(100);
    chk("glitch_back_idle", uart.rx_state, IDLE);
    tick(900);
    chk("glitch_no_echo", rxd_low_cnt - base, 0);

    // Framing error: stop bit 0 discards 0xA5.
    send_byte(8'hA5, 1'b0);
    tick(1000);
    chk("frame_no_echo", rxd_low_cnt - base, 0);
    chk("frame_fifo_empty", dut.fifo_count, 0);
    chk("frame_no_byte", got_q.size() - got_rd, 0);

    // Overflow: 17 bytes into a 16-deep FIFO, last one dropped.
    uart.rts = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(8'h10 + i), 1'b1);
      if (i < 16) exp_q.push_back(8'(8'h10 + i));
    end
    chk("ovf_count", dut.fifo_count, 16);
    chk("ovf_cts", uart.cts, 1'b0);
    uart.rts = 1'b1;
    wait_echo(16, "ovf");
    tick(1200);
    chk("ovf_dropped", got_q.size() - got_rd, 0);

    // Reset during echo data bit 3 of 0xC3 (bit 3 = 0).
    uart.rts = 1'b0;
    send_byte(8'hC3, 1'b1);
    send_byte(8'h96, 1'b1);
    uart.rts = 1'b1;
    m = cyc;
    tick(1);
    tick(4 * BD + 40);
    chk("mid_bit3_low", uart.rxd, 1'b0);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_rxd", uart.rxd, 1'b1);
    chk("mid_rst_cts", uart.cts, 1'b0);
    chk("mid_rst_tx_state", uart.tx_state, IDLE);
    tick(1);
    reset = 1'b0;
    tick(2);
    chk("mid_rst_fifo_empty", dut.fifo_count, 0);
    base = rxd_low_cnt;
    tick(1500);
    chk("mid_rst_no_echo", rxd_low_cnt - base, 0);
    got_rd = got_q.size();

    // Drop rts mid-character: current byte completes, next waits.
    uart.rts = 1'b0;
    send_byte(8'h5A, 1'b1);
    send_byte(8'h81, 1'b1);
    exp_q.push_back(8'h5A);
    uart.rts = 1'b1;
    m = cyc;
    tick(100);
    uart.rts = 1'b0;
    tick(770);
    chk("rts_drop_stop_bit", uart.rxd, 1'b1);
    tick(2);
    chk("rts_drop_no_start", uart.rxd, 1'b1);
    chk("rts_drop_tx_idle", uart.tx_state, IDLE);
    wait_echo(1, "rts_drop");
    tick(500);
    chk("rts_drop_held", got_q.size() - got_rd, 0);
    chk("rts_drop_count", dut.fifo_count, 1);
    exp_q.push_back(8'h81);
    uart.rts = 1'b1;
    tick(1);
    chk("rts_resume_start", uart.rxd, 1'b0);
    wait_echo(1, "rts_resume");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dce_loopback.md
Name: dce_loopback

Overview:
- UART DCE loopback model for transactor-based UART testbenches.
- Receives 8N1 characters serially from the DTE on txd, buffers them in a FIFO, and retransmits each byte unchanged on rxd.
- Uses RTS/CTS hardware flow control.
- Exposes its baud divisor as a 32-bit signal `DBR` so the testbench transactor can match its bit rate.

Parameters:
- BAUD_DIV, 87, clock cycles per UART bit (10 MHz / 115200); legal range 4 to 2^31-1.
- FIFO_DEPTH, 16, loopback buffer depth in bytes; must be a power of 2 and at least 4.
- CTS_HEADROOM, 2, free entries that must remain for cts to stay asserted.

Ports:
- clock  input  1  sole clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rts    input  1  from DTE; 1 = DTE ready to receive, which permits DCE transmit.
- cts    output 1  to DTE; 1 = DCE able to accept characters.
- txd    input  1  serial data from DTE (DCE receive line); idle high.
- rxd    output 1  serial data to DTE (DCE transmit line); idle high; registered.
- Internal signal `DBR`: 32-bit, constant, equal to BAUD_DIV, fixed name, readable by hierarchical reference.

Behaviour:
- Reset (synchronous, active-high): while reset=1 and in the cycle following it:
  - rxd=1, cts=0.
  - FIFO empty; receive and transmit FSMs in IDLE; counters 0.
  - Synchronizer flops preset to 1.
- txd passes through a 2-flop synchronizer. All receive timing references the synchronized signal, s_txd.
- Receive FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a falling edge on s_txd loads the bit counter and moves to START.
  - START: after BAUD_DIV/2 cycles (integer division), sample s_txd. If 1, this is a glitch: return to IDLE with nothing pushed. If 0, go to DATA.
  - DATA: sample 8 bits, one every BAUD_DIV cycles, LSB first, into a shift register.
  - STOP: sample BAUD_DIV cycles after the last data bit.
    - Sample = 1 and FIFO not full: push the byte in that same cycle.
    - Sample = 0 (framing error): discard the byte.
    - FIFO full: drop the byte; FIFO contents are unchanged.
  - Return to IDLE immediately after the stop sample, so a back-to-back start bit is detected.
- cts = 1 when not in reset and (FIFO_DEPTH - count) > CTS_HEADROOM. It is registered and updates the cycle after the count changes.
- Transmit FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: when FIFO not empty and rts=1 (both sampled the same cycle), pop the byte. rxd drives 0 from the next cycle.
  - START bit, 8 data bits LSB first, and stop bit (1) each last exactly BAUD_DIV cycles.
  - rts is only checked in IDLE. Deasserting rts mid-character lets the character complete.
  - After the stop bit, return to IDLE. The next character may start on the following cycle.
- Latency: push cycle N; the transmit FSM sees the byte non-empty at N+1; rxd falls at N+2 (FIFO is registered, no bypass).
- FIFO:
  - Simultaneous push and pop in the same cycle are both honoured; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Order is strictly preserved.
- Receiver and transmitter are fully independent (full duplex).
- Reset asserted mid-character aborts both FSMs, empties the FIFO and forces rxd=1 in the following cycle.

Decomposition:
- Package dce_pkg holds:
  - DATA_W=8 and BAUD_DIV_DEFAULT=87.
  - Enum uart_state_t {IDLE, START, DATA, STOP}, shared by both FSMs.
- One natural sub-module: dce_byte_fifo, a synchronous FIFO.
  - Parameters: DEPTH, WIDTH.
  - Ports: clock, reset, push, din, pop, dout, empty, full, count.
- Receive FSM, transmit FSM, synchronizer and cts logic live in dce_loopback.

Test Plan:
- Reset held 10 cycles, then released:
  - During reset: rxd=1, cts=0.
  - One cycle after release: cts=1.
  - DBR reads 87 hierarchically.
- rts=1, DTE sends 0x55 at BAUD_DIV=87:
  - rxd falls 4 cycles after the stop-bit sample point (2 synchronizer + 2 FSM).
  - Each bit lasts 87 cycles; decoded byte is 0x55.
- rts=0, send 0x00..0x0D (14 bytes):
  - rxd stays 1 throughout.
  - cts drops to 0 after the 14th push.
  - Then raise rts: 14 bytes echoed in order, back-to-back.
  - cts returns to 1 after the first pop.
- Glitch and framing error:
  - txd low for 20 cycles, then high: nothing pushed; rxd stays 1.
  - Character 0xA5 sent with stop bit 0: discarded, no echo.
- Overflow: rts=0, ignore cts, send 17 bytes 0x10..0x20, then raise rts:
  - 0x10..0x1F echoed.
  - 0x20 dropped.
- Mid-character events:
  - Reset asserted during echo data bit 3: rxd=1 the next cycle; FIFO empty afterwards.
  - Drop rts during echo: the current byte completes; no new byte starts until rts=1.
